// File: rtl/am2910_lite_pkg.sv
// Shared opcodes, default sizes and the condition-pass helper for the
// am2910_lite microprogram sequencer.
package am2910_lite_pkg;

  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  localparam logic [2:0] OP_JZ   = 3'd0;
  localparam logic [2:0] OP_CJS  = 3'd1;
  localparam logic [2:0] OP_JMAP = 3'd2;
  localparam logic [2:0] OP_CJP  = 3'd3;
  localparam logic [2:0] OP_PUSH = 3'd4;
  localparam logic [2:0] OP_RPCT = 3'd5;
  localparam logic [2:0] OP_CRTN = 3'd6;
  localparam logic [2:0] OP_LOOP = 3'd7;

  // Condition passes when it is disabled or when the active-low code is asserted.
  function automatic logic calc_pass(input logic ccen_lo, input logic cc_lo);
    return ccen_lo | ~cc_lo;
  endfunction

endpackage

// File: rtl/am2910_lite_seq_stack.sv
// LIFO return-address stack. A push into a full stack replaces the top entry
// and a pop from an empty stack does nothing; tos reads 0 while empty.
module seq_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          cp,
  input  logic          reset_lo,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] tos,
  output logic          full_lo,
  output logic          empty
);

  localparam int IW  = $clog2(DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [IW-1:0]  IDX_TOP = IW'(DEPTH - 1);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           full_lo_q;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;

  // Pointer update and write slot selection; clear has priority over push/pop.
  always_comb begin
    sp_d   = sp_q;
    wr_en  = 1'b0;
    wr_idx = sp_q[IW-1:0];
    if (clr) begin
      sp_d = '0;
    end else if (push) begin
      wr_en = 1'b1;
      if (sp_q == SP_FULL) begin
        wr_idx = IDX_TOP;
      end else begin
        sp_d = sp_q + 1'b1;
      end
    end else if (pop && (sp_q != '0)) begin
      sp_d = sp_q - 1'b1;
    end
  end

  // Stack pointer and registered full flag.
  always_ff @(posedge cp) begin
    if (!reset_lo) begin
      sp_q      <= '0;
      full_lo_q <= 1'b1;
    end else begin
      sp_q      <= sp_d;
      full_lo_q <= (sp_d != SP_FULL);
    end
  end

  // Entry storage; contents are not reset, only the pointer is.
  always_ff @(posedge cp) begin
    if (reset_lo && wr_en) begin
      mem_q[wr_idx] <= din;
    end
  end

  assign rd_idx  = IW'(sp_q - 1'b1);
  assign empty   = (sp_q == '0);
  assign tos     = empty ? '0 : mem_q[rd_idx];
  assign full_lo = full_lo_q;

endmodule

// File: rtl/am2910_lite_seq.sv
// Am2910-subset microprogram sequencer: picks the next microaddress from
// uPC, branch data, the mapping PROM or the return stack, and keeps a
// repeat counter for RPCT loops.
module am2910_lite_seq
  import am2910_lite_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          cp,
  input  logic          reset_lo,
  input  logic [2:0]    seq_op,
  input  logic          cc_lo,
  input  logic          ccen_lo,
  input  logic          ci,
  input  logic [AW-1:0] d_in,
  input  logic [AW-1:0] map_in,
  output logic [AW-1:0] y_addr,
  output logic          full_lo,
  output logic          cnt_zero
);

  logic [AW-1:0] upc_q, upc_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] y_d;
  logic [AW-1:0] tos;
  logic          pass;
  logic          push, pop, clr;
  logic          empty;

  assign pass     = calc_pass(ccen_lo, cc_lo);
  assign cnt_zero = (cnt_q == '0);

  // Opcode decode: next address, stack request and counter next value.
  always_comb begin
    y_d   = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
    cnt_d = cnt_q;
    if (!reset_lo) begin
      y_d = '0;
    end else begin
      case (seq_op)
        OP_JZ: begin
          y_d = '0;
          clr = 1'b1;
        end
        OP_CJS: begin
          if (pass) begin
            y_d  = d_in;
            push = 1'b1;
          end
        end
        OP_JMAP: y_d = map_in;
        OP_CJP: begin
          if (pass) y_d = d_in;
        end
        OP_PUSH: begin
          push = 1'b1;
          if (pass) cnt_d = d_in;
        end
        OP_RPCT: begin
          if (!cnt_zero) begin
            y_d   = d_in;
            cnt_d = cnt_q - 1'b1;
          end
        end
        OP_CRTN: begin
          if (pass) begin
            y_d = tos;
            pop = ~empty;
          end
        end
        OP_LOOP: begin
          if (pass) pop = ~empty;
          else      y_d = tos;
        end
        default: y_d = upc_q;
      endcase
    end
  end

  assign y_addr = y_d;
  assign upc_d  = y_d + AW'(ci);

  // uPC and repeat counter registers.
  always_ff @(posedge cp) begin
    if (!reset_lo) begin
      upc_q <= '0;
      cnt_q <= '0;
    end else begin
      upc_q <= upc_d;
      cnt_q <= cnt_d;
    end
  end

  // The stack always captures the current uPC as the return address.
  seq_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_stack (
    .cp       (cp),
    .reset_lo (reset_lo),
    .push     (push),
    .pop      (pop),
    .clr      (clr),
    .din      (upc_q),
    .tos      (tos),
    .full_lo  (full_lo),
    .empty    (empty)
  );

endmodule

// File: tb/tb_am2910_lite_seq.sv
// Self-checking bench for am2910_lite_seq: directed scenarios followed by
// randomized opcodes, all compared against a queue-based reference model.
module tb_am2910_lite_seq;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  localparam logic [2:0] JZ = 3'd0, CJS = 3'd1, JMAP = 3'd2, CJP = 3'd3,
                         PSH = 3'd4, RPCT = 3'd5, CRTN = 3'd6, LOOP = 3'd7;

  logic          cp = 1'b0;
  logic          reset_lo = 1'b0;
  logic [2:0]    seq_op = 3'd0;
  logic          cc_lo = 1'b1;
  logic          ccen_lo = 1'b1;
  logic          ci = 1'b1;
  logic [AW-1:0] d_in = '0;
  logic [AW-1:0] map_in = '0;
  logic [AW-1:0] y_addr;
  logic          full_lo;
  logic          cnt_zero;

  am2910_lite_seq #(.AW(AW), .DEPTH(DEPTH)) dut (
    .cp       (cp),
    .reset_lo (reset_lo),
    .seq_op   (seq_op),
    .cc_lo    (cc_lo),
    .ccen_lo  (ccen_lo),
    .ci       (ci),
    .d_in     (d_in),
    .map_in   (map_in),
    .y_addr   (y_addr),
    .full_lo  (full_lo),
    .cnt_zero (cnt_zero)
  );

  always #5 cp = ~cp;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: plain integers and a queue as the return stack.
  int m_upc = 0;
  int m_cnt = 0;
  int m_stk[$];
  int last_y;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int m_tos();
    return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
  endfunction

  function automatic int m_next_y(input logic rst, input logic [2:0] op,
                                  input logic cc, input logic ccen,
                                  input int d, input int m);
    bit p;
    p = ccen || !cc;
    if (!rst) return 0;
    case (op)
      JZ:      return 0;
      CJS:     return p ? d : m_upc;
      JMAP:    return m;
      CJP:     return p ? d : m_upc;
      PSH:     return m_upc;
      RPCT:    return (m_cnt != 0) ? d : m_upc;
      CRTN:    return p ? m_tos() : m_upc;
      default: return p ? m_upc : m_tos();
    endcase
  endfunction

  task automatic m_push(input int v);
    if (m_stk.size() == DEPTH) m_stk[DEPTH-1] = v;
    else m_stk.push_back(v);
  endtask

  task automatic m_pop();
    if (m_stk.size() > 0) void'(m_stk.pop_back());
  endtask

  // One sequencer cycle: drive, check y before the edge, advance model, check flags.
  task automatic cyc(input logic rst, input logic [2:0] op, input logic cc,
                     input logic ccen, input logic c, input int d, input int m);
    int ey;
    bit p;
    @(negedge cp);
    reset_lo = rst; seq_op = op; cc_lo = cc; ccen_lo = ccen; ci = c;
    d_in = AW'(d); map_in = AW'(m);
    #1;
    ey = m_next_y(rst, op, cc, ccen, d, m);
    last_y = int'(y_addr);
    check("y_addr", last_y, ey);
    p = ccen || !cc;
    if (!rst) begin
      m_upc = 0; m_cnt = 0; m_stk.delete();
    end else begin
      case (op)
        JZ:   m_stk.delete();
        CJS:  if (p) m_push(m_upc);
        PSH:  begin m_push(m_upc); if (p) m_cnt = d; end
        RPCT: if (m_cnt != 0) m_cnt = m_cnt - 1;
        CRTN: if (p) m_pop();
        LOOP: if (p) m_pop();
        default: ;
      endcase
      m_upc = (ey + int'(c)) % 256;
    end
    @(posedge cp);
    #1;
    check("full_lo", int'(full_lo), (m_stk.size() == DEPTH) ? 0 : 1);
    check("cnt_zero", int'(cnt_zero), (m_cnt == 0) ? 1 : 0);
  endtask

  initial begin
    // Reset held over a passing CJP: y stays 0.
    cyc(0, CJP, 0, 0, 1, 'h55, 0);
    check("rst_y0", last_y, 0);
    cyc(0, CJP, 0, 0, 1, 'h55, 0);
    check("rst_y1", last_y, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, CJP, 1, 0, 1, 'h55, 0);
      check("cont_y", last_y, i);
    end
    check("rst_full", int'(full_lo), 1);

    // Call from address 0x10, return to 0x11.
    cyc(1, CJP, 0, 0, 1, 'h10, 0);
    cyc(1, CJS, 0, 0, 1, 'h40, 0);
    check("cjs_y", last_y, 'h40);
    cyc(1, CRTN, 0, 0, 1, 0, 0);
    check("crtn_y", last_y, 'h11);

    // Repeat loop with counter loaded to 3.
    cyc(1, JZ, 1, 1, 1, 0, 0);
    cyc(1, CJP, 0, 0, 1, 'h1F, 0);
    cyc(1, PSH, 0, 0, 1, 3, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, RPCT, 1, 1, 1, 'h30, 0);
      check("rpct_y", last_y, 'h30);
    end
    check("rpct_zero", int'(cnt_zero), 1);
    cyc(1, RPCT, 1, 1, 1, 'h30, 0);
    check("rpct_exit", last_y, 'h31);

    // Stack overflow replaces TOS, underflow returns 0.
    cyc(1, JZ, 1, 1, 1, 0, 0);
    cyc(1, CJS, 0, 0, 1, 'h60, 0);
    cyc(1, CJS, 0, 0, 1, 'h70, 0);
    cyc(1, CJS, 0, 0, 1, 'h80, 0);
    cyc(1, CJS, 0, 0, 1, 'h98, 0);
    check("full4", int'(full_lo), 0);
    cyc(1, CJS, 0, 0, 1, 'h10, 0);
    check("full5", int'(full_lo), 0);
    cyc(1, CRTN, 0, 0, 1, 0, 0);
    check("ovf_tos", last_y, 'h99);
    for (int i = 0; i < 4; i++) cyc(1, CRTN, 0, 0, 1, 0, 0);
    check("udf_y", last_y, 0);

    // LOOP fail jumps to TOS, pass falls through and pops.
    cyc(1, JZ, 1, 1, 1, 0, 0);
    cyc(1, CJP, 0, 0, 1, 'h4F, 0);
    cyc(1, PSH, 1, 0, 1, 'hEE, 0);
    cyc(1, LOOP, 1, 0, 1, 0, 0);
    check("loop_fail", last_y, 'h50);
    cyc(1, LOOP, 0, 0, 1, 0, 0);
    check("loop_pass", last_y, 'h51);

    // uPC wrap, then freeze with ci=0.
    cyc(1, CJP, 0, 0, 1, 'hFF, 0);
    cyc(1, CJP, 1, 0, 0, 0, 0);
    check("wrap", last_y, 0);
    cyc(1, CJP, 1, 0, 0, 0, 0);
    check("freeze", last_y, 0);

    // Reset with depth 3 and counter 7.
    cyc(1, JZ, 1, 1, 1, 0, 0);
    cyc(1, CJS, 0, 0, 1, 'h21, 0);
    cyc(1, CJS, 0, 0, 1, 'h31, 0);
    cyc(1, PSH, 0, 0, 1, 7, 0);
    cyc(0, PSH, 0, 0, 1, 9, 0);
    check("mrst_cnt", int'(cnt_zero), 1);
    cyc(1, CRTN, 0, 0, 1, 0, 0);
    check("mrst_sp", last_y, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 39) != 0), 3'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) != 0), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
